fifo_wr_arbiter: RTL and testbench

- Round-robin burst arbiter that shares the single write port of the 8-bit FIFO (fifo_generator_0 wrapper) between NUM_REQ independent producers.
- Each producer presents a valid/ready byte stream. The arbiter grants one producer at a time for a burst of up to BURST_LEN words and drives fifo_wr_en/fifo_wdata.
- Sits between the producer modules and the FIFO instance in the top level, replacing the dedicated single-writer block.

---
 rtl/fifo_ctrl_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write/read-side control blocks.
// Holds the arbiter state encoding, default widths and a constant clog2.
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_BURST_LEN = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or above rr_ptr, wrapping.
// Shared by the write arbiter and the read-side scheduler.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   win_idx
);

    logic               found;
    int unsigned        idx;
    logic [NUM_REQ-1:0] valid_sh;

    always_comb begin
        winner   = '0;
        win_idx  = '0;
        found    = 1'b0;
        idx      = 0;
        valid_sh = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx      = (32'(rr_ptr) + k) % NUM_REQ;
            valid_sh = req_valid >> idx;
            if (!found && valid_sh[0]) begin
                found   = 1'b1;
                winner  = NUM_REQ'(1) << idx;
                win_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// One arbitration cycle in IDLE, then up to BURST_LEN beats in XFER; fifo_full stalls.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [15:0]               words_total
);

    localparam int unsigned IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int unsigned CNT_W = clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    state_t             state;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [CNT_W-1:0]   beat_cnt;
    logic [DATA_W-1:0]  wdata_sel;
    logic               in_xfer;
    logic               cur_valid;
    logic               fire;
    logic               burst_done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (pick_onehot),
        .win_idx   (pick_idx)
    );

    // grant is one-hot in XFER and zero in IDLE, so it doubles as the data/valid mux select
    always_comb begin
        wdata_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                wdata_sel = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        in_xfer    = (state == XFER);
        cur_valid  = |(req_valid & grant);
        fire       = in_xfer && cur_valid && !fifo_full;
        burst_done = fire && (beat_cnt == LAST_BEAT);
        next_ptr   = (gidx == LAST_IDX) ? '0 : gidx + IDX_W'(1);
        fifo_wr_en = fire;
        fifo_wdata = in_xfer ? wdata_sel : '0;
        req_ready  = (in_xfer && !fifo_full) ? grant : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            grant       <= '0;
            gidx        <= '0;
            busy        <= 1'b0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            words_total <= '0;
        end else begin
            if (fire) begin
                beat_cnt    <= beat_cnt + CNT_W'(1);
                words_total <= words_total + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state    <= XFER;
                        grant    <= pick_onehot;
                        gidx     <= pick_idx;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                XFER: begin
                    // a dry requester releases immediately; a full FIFO only stalls
                    if (burst_done || !cur_valid) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with queue-based producers and a FIFO-order scoreboard.
// A second instance with BURST_LEN=256 exercises the words_total wrap.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] words_total;

    fifo_wr_arbiter #(.NUM_REQ(2), .DATA_W(8), .BURST_LEN(4)) dut (
        .sys_clk(clk), .sys_rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wdata(fifo_wdata), .grant(grant), .busy(busy), .words_total(words_total)
    );

    logic        w_rst;
    logic [1:0]  w_valid;
    logic [15:0] w_data;
    logic [1:0]  w_ready;
    logic        w_full;
    logic        w_wr_en;
    logic [7:0]  w_wdata;
    logic [1:0]  w_grant;
    logic        w_busy;
    logic [15:0] w_total;

    fifo_wr_arbiter #(.NUM_REQ(2), .DATA_W(8), .BURST_LEN(256)) dut_wrap (
        .sys_clk(clk), .sys_rst(w_rst), .req_valid(w_valid), .req_data(w_data),
        .req_ready(w_ready), .fifo_full(w_full), .fifo_wr_en(w_wr_en),
        .fifo_wdata(w_wdata), .grant(w_grant), .busy(w_busy), .words_total(w_total)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] sb[$];
    int         run_len[$];
    int         run_gap[$];
    logic [1:0] run_grant[$];
    int         cur_gap;
    bit         prev_wr;
    bit         had_run;
    int         nwr;

    logic [1:0]  ob_grant, ob_ready;
    logic        ob_wr_en, ob_busy;
    logic [7:0]  ob_data;
    logic [15:0] ob_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid[0]   = (q0.size() != 0);
        req_valid[1]   = (q1.size() != 0);
        req_data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
        req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic clear_runs();
        run_len.delete();
        run_gap.delete();
        run_grant.delete();
        cur_gap = 0;
        prev_wr = 1'b0;
        had_run = 1'b0;
        nwr     = 0;
    endtask

    // one clock: observe at negedge, retire accepted producer words at posedge+1
    task automatic cyc();
        logic [1:0] acc;
        logic [7:0] exp_b;
        @(negedge clk);
        ob_grant = grant;
        ob_ready = req_ready;
        ob_wr_en = fifo_wr_en;
        ob_busy  = busy;
        ob_data  = fifo_wdata;
        ob_total = words_total;
        acc = 2'b00;
        if (!rst) begin
            acc = req_valid & req_ready;
            chk("wr_en_vs_handshake", fifo_wr_en, |acc);
            chk("ready_onehot0", $countones(req_ready) <= 1, 1'b1);
            if (fifo_wr_en) begin
                nwr++;
                chk("no_write_when_full", fifo_full, 1'b0);
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: observed write %0h expected none", fifo_wdata);
                end
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    chk("fifo_data", fifo_wdata, exp_b);
                end
                if (!prev_wr) begin
                    if (had_run) run_gap.push_back(cur_gap);
                    run_len.push_back(1);
                    run_grant.push_back(grant);
                    had_run = 1'b1;
                end else begin
                    run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
                end
                cur_gap = 0;
            end else begin
                cur_gap++;
            end
            prev_wr = fifo_wr_en;
        end
        @(posedge clk);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_timeout", n < budget, 1'b1);
        repeat (3) cyc();
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic run_until_writes(input int target, input int budget);
        int n;
        n = 0;
        while (nwr < target && n < budget) begin
            cyc();
            n++;
        end
        chk("write_wait_timeout", n < budget, 1'b1);
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        sb.delete();
        fifo_full = 1'b0;
        rst = 1'b1;
        drive();
        repeat (2) cyc();
        rst = 1'b0;
        clear_runs();
    endtask

    initial begin
        int n;
        int cycles;
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = 2'b11;
        req_data  = 16'hB1A1;
        w_rst     = 1'b1;
        w_valid   = 2'b00;
        w_data    = 16'h005A;
        w_full    = 1'b0;
        clear_runs();

        // reset state with both requesters asserting valid
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_total", words_total, 16'h0000);
        chk("rst_wr_en", fifo_wr_en, 1'b0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_wdata", fifo_wdata, 8'h00);

        // single requester: 10 bytes in bursts 4,4,2
        do_reset();
        for (int i = 0; i < 10; i++) begin
            q0.push_back(8'(i));
            sb.push_back(8'(i));
        end
        drive();
        run_drain(100);
        chk("t1_runs", run_len.size(), 3);
        if (run_len.size() == 3) begin
            chk("t1_run0", run_len[0], 4);
            chk("t1_run1", run_len[1], 4);
            chk("t1_run2", run_len[2], 2);
            chk("t1_gap0", run_gap[0], 1);
            chk("t1_gap1", run_gap[1], 1);
            chk("t1_grant0", run_grant[0], 2'b01);
        end
        chk("t1_total", ob_total, 16'd10);
        chk("t1_idle_busy", ob_busy, 1'b0);

        // both always valid: A0-A3, B0-B3, A4-A7, B4-B7
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'hA0 + 8'(i));
            q1.push_back(8'hB0 + 8'(i));
        end
        for (int i = 0; i < 4; i++) sb.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) sb.push_back(8'hB0 + 8'(i));
        for (int i = 4; i < 8; i++) sb.push_back(8'hA0 + 8'(i));
        for (int i = 4; i < 8; i++) sb.push_back(8'hB0 + 8'(i));
        drive();
        run_drain(100);
        chk("t2_runs", run_len.size(), 4);
        if (run_len.size() == 4) begin
            chk("t2_grant0", run_grant[0], 2'b01);
            chk("t2_grant1", run_grant[1], 2'b10);
            chk("t2_grant2", run_grant[2], 2'b01);
            chk("t2_grant3", run_grant[3], 2'b10);
            chk("t2_len3", run_len[3], 4);
        end
        chk("t2_total", ob_total, 16'd16);

        // backpressure: full for 5 cycles after 2 beats
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'hC0 + 8'(i));
            sb.push_back(8'hC0 + 8'(i));
        end
        drive();
        run_until_writes(2, 20);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_full_wr_en", ob_wr_en, 1'b0);
            chk("t3_full_ready", ob_ready, 2'b00);
            chk("t3_full_grant", ob_grant, 2'b01);
            chk("t3_full_busy", ob_busy, 1'b1);
        end
        fifo_full = 1'b0;
        run_drain(50);
        chk("t3_runs", run_len.size(), 2);
        if (run_len.size() == 2) begin
            chk("t3_len1", run_len[1], 2);
            chk("t3_gap", run_gap[0], 5);
        end
        chk("t3_total", ob_total, 16'd4);

        // early release from requester 1, then requester 0 wins
        do_reset();
        q1.push_back(8'hD0);
        sb.push_back(8'hD0);
        drive();
        run_until_writes(1, 10);
        chk("t4_grant_r1", ob_grant, 2'b10);
        cyc();
        chk("t4_dry_wr_en", ob_wr_en, 1'b0);
        chk("t4_dry_busy", ob_busy, 1'b1);
        q0.push_back(8'hE0);
        q1.push_back(8'hF0);
        sb.push_back(8'hE0);
        sb.push_back(8'hF0);
        drive();
        cyc();
        chk("t4_idle_busy", ob_busy, 1'b0);
        chk("t4_idle_grant", ob_grant, 2'b00);
        cyc();
        chk("t4_rr_grant", ob_grant, 2'b01);
        chk("t4_rr_data", ob_data, 8'hE0);
        run_drain(30);

        // reset during beat 2 of requester 1's burst
        do_reset();
        for (int i = 0; i < 6; i++) q0.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) q1.push_back(8'h20 + 8'(i));
        for (int i = 0; i < 4; i++) sb.push_back(8'h10 + 8'(i));
        sb.push_back(8'h20);
        sb.push_back(8'h21);
        drive();
        run_until_writes(6, 30);
        chk("t5_pre_grant", ob_grant, 2'b10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sb.push_back(8'h14);
        sb.push_back(8'h15);
        sb.push_back(8'h22);
        sb.push_back(8'h23);
        clear_runs();
        cyc();
        chk("t5_grant", ob_grant, 2'b00);
        chk("t5_busy", ob_busy, 1'b0);
        chk("t5_total", ob_total, 16'h0000);
        chk("t5_wr_en", ob_wr_en, 1'b0);
        cyc();
        chk("t5_restart_grant", ob_grant, 2'b01);
        run_drain(50);
        chk("t5_final_total", ob_total, 16'd4);

        // words_total wrap on the BURST_LEN=256 instance
        @(posedge clk);
        #1;
        w_rst   = 1'b0;
        w_valid = 2'b01;
        n = 0;
        cycles = 0;
        while (n < 65537 && cycles < 70000) begin
            @(negedge clk);
            cycles++;
            if (w_wr_en) begin
                n++;
                if (n == 65536) chk("wrap_pre_total", w_total, 16'hFFFF);
            end
        end
        chk("wrap_timeout", cycles < 70000, 1'b1);
        @(posedge clk);
        #1;
        w_valid = 2'b00;
        @(negedge clk);
        chk("wrap_total", w_total, 16'h0001);
        chk("wrap_wr_en", w_wr_en, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
